// File: rtl/trng_seed_arbiter.sv
// Consumer-side scheduler for the TRNG byte FIFO: warm-up discard, repetition-count
// health test, seed-word packing and round-robin delivery to two requesters.
module trng_seed_arbiter #(
    parameter int unsigned WORD_BYTES   = 4,
    parameter int unsigned WARMUP_BYTES = 16,
    parameter int unsigned REP_LIMIT    = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    fifo_empty,
    input  logic [7:0]              fifo_dout,
    output logic                    fifo_rd_en,
    input  logic [1:0]              req,
    input  logic                    clear_fault,
    output logic [1:0]              gnt,
    output logic                    seed_valid,
    output logic [8*WORD_BYTES-1:0] seed_data,
    output logic                    health_fault
);

    localparam int unsigned SEED_W  = 8 * WORD_BYTES;
    localparam logic [8:0]  WARM_N  = 9'(WARMUP_BYTES);
    localparam logic [3:0]  BYTES_N = 4'(WORD_BYTES);
    localparam logic [3:0]  REP_N   = 4'(REP_LIMIT);

    typedef enum logic [2:0] {
        S_WARMUP,
        S_FILL,
        S_READY,
        S_GRANT,
        S_FAULT
    } state_e;

    state_e              state_q, state_d;
    logic                rd_pending_q, rd_pending_d;
    logic [7:0]          warm_cnt_q, warm_cnt_d;
    logic [3:0]          byte_cnt_q, byte_cnt_d;
    logic [3:0]          rep_cnt_q, rep_cnt_d;
    logic [7:0]          prev_byte_q, prev_byte_d;
    logic                prev_valid_q, prev_valid_d;
    logic [SEED_W-1:0]   word_q, word_d;
    logic                rr_q, rr_d;
    logic [1:0]          gnt_q, gnt_d;
    logic                seed_valid_q, seed_valid_d;
    logic [SEED_W-1:0]   seed_data_q, seed_data_d;

    logic                capture;
    logic [3:0]          rep_next;
    logic                rep_trip;
    logic [1:0]          winner;

    // Reads are gated by reset_n so the strobe stays low while reset is held.
    assign fifo_rd_en = reset_n && ((state_q == S_WARMUP) || (state_q == S_FILL))
                        && !fifo_empty && !rd_pending_q;

    assign capture  = rd_pending_q;
    assign rep_next = (prev_valid_q && (fifo_dout == prev_byte_q)) ? rep_cnt_q + 4'd1 : 4'd1;
    assign rep_trip = (rep_next == REP_N);

    always_comb begin
        winner = 2'b01;
        if (rr_q) begin
            winner = req[1] ? 2'b10 : 2'b01;
        end else begin
            winner = req[0] ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_pending_d = rd_pending_q;
        warm_cnt_d   = warm_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        rep_cnt_d    = rep_cnt_q;
        prev_byte_d  = prev_byte_q;
        prev_valid_d = prev_valid_q;
        word_d       = word_q;
        rr_d         = rr_q;
        gnt_d        = '0;
        seed_valid_d = 1'b0;
        seed_data_d  = seed_data_q;

        if (fifo_rd_en) begin
            rd_pending_d = 1'b1;
        end else if (capture) begin
            rd_pending_d = 1'b0;
        end

        if (capture) begin
            rep_cnt_d    = rep_next;
            prev_byte_d  = fifo_dout;
            prev_valid_d = 1'b1;
        end

        case (state_q)
            S_WARMUP: begin
                if (capture) begin
                    if (rep_trip) begin
                        state_d = S_FAULT;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 8'd1;
                        if ({1'b0, warm_cnt_q} + 9'd1 >= WARM_N) begin
                            state_d = S_FILL;
                        end
                    end
                end else if (WARM_N == 9'd0) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (capture) begin
                    if (rep_trip) begin
                        state_d    = S_FAULT;
                        byte_cnt_d = '0;
                    end else begin
                        word_d     = (word_q << 8) | SEED_W'(fifo_dout);
                        byte_cnt_d = byte_cnt_q + 4'd1;
                        if (byte_cnt_q + 4'd1 == BYTES_N) begin
                            state_d = S_READY;
                        end
                    end
                end
            end
            S_READY: begin
                if (|req) begin
                    state_d      = S_GRANT;
                    gnt_d        = winner;
                    seed_valid_d = 1'b1;
                    seed_data_d  = word_q;
                    rr_d         = ~rr_q;
                end
            end
            S_GRANT: begin
                state_d    = S_FILL;
                byte_cnt_d = '0;
            end
            S_FAULT: begin
                if (clear_fault) begin
                    state_d      = S_WARMUP;
                    warm_cnt_d   = '0;
                    byte_cnt_d   = '0;
                    rep_cnt_d    = '0;
                    prev_valid_d = 1'b0;
                end
            end
            default: state_d = S_WARMUP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_WARMUP;
            rd_pending_q <= 1'b0;
            warm_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            rep_cnt_q    <= '0;
            prev_byte_q  <= '0;
            prev_valid_q <= 1'b0;
            word_q       <= '0;
            rr_q         <= 1'b0;
            gnt_q        <= '0;
            seed_valid_q <= 1'b0;
            seed_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= rd_pending_d;
            warm_cnt_q   <= warm_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            rep_cnt_q    <= rep_cnt_d;
            prev_byte_q  <= prev_byte_d;
            prev_valid_q <= prev_valid_d;
            word_q       <= word_d;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            seed_valid_q <= seed_valid_d;
            seed_data_q  <= seed_data_d;
        end
    end

    assign gnt          = gnt_q;
    assign seed_valid   = seed_valid_q;
    assign seed_data    = seed_data_q;
    assign health_fault = (state_q == S_FAULT);

endmodule

// File: tb/tb_trng_seed_arbiter.sv
// Bench for trng_seed_arbiter: FIFO/requester environment, queue-based reference model
// compared every cycle, directed scenarios pinned with literal seed words, then random traffic.
module tb_trng_seed_arbiter;

    localparam int WB = 4;
    localparam int WU = 16;
    localparam int RL = 4;
    localparam int SW = 8 * WB;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic          fifo_rd_en;
    logic [1:0]    req;
    logic          clear_fault;
    logic [1:0]    gnt;
    logic          seed_valid;
    logic [SW-1:0] seed_data;
    logic          health_fault;

    always #5 clk = ~clk;

    trng_seed_arbiter #(
        .WORD_BYTES  (WB),
        .WARMUP_BYTES(WU),
        .REP_LIMIT   (RL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .fifo_rd_en  (fifo_rd_en),
        .req         (req),
        .clear_fault (clear_fault),
        .gnt         (gnt),
        .seed_valid  (seed_valid),
        .seed_data   (seed_data),
        .health_fault(health_fault)
    );

    int n_vec = 0;
    int n_err = 0;

    // environment
    logic [7:0]  fq[$];
    logic        stall = 1'b0;
    logic        rd_seen = 1'b0;
    logic [1:0]  g_seen = '0;
    logic [1:0]  req_want = '0;
    logic        rand_mode = 1'b0;
    logic        clr_next = 1'b0;
    int          n_reads = 0;
    logic [63:0] dseed[$];
    logic [1:0]  dgnt[$];
    logic [63:0] mseed[$];
    logic [1:0]  mgnt[$];

    // reference model
    int          m_disc;
    logic [7:0]  m_wq[$];
    int          m_run;
    logic [7:0]  m_last;
    logic        m_have_last;
    logic        m_fault;
    logic        m_ready;
    logic [63:0] m_word;
    logic        m_grant;
    logic [1:0]  m_gvec;
    logic        m_rr;
    logic [63:0] m_seed;
    logic        m_pend;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_disc = WU;
        m_wq.delete();
        m_run = 0;
        m_last = '0;
        m_have_last = 1'b0;
        m_fault = 1'b0;
        m_ready = 1'b0;
        m_word = '0;
        m_grant = 1'b0;
        m_gvec = '0;
        m_rr = 1'b0;
        m_seed = '0;
        m_pend = 1'b0;
    endfunction

    function automatic void model_capture(input logic [7:0] b);
        logic [63:0] w;
        m_run = (m_have_last && b == m_last) ? m_run + 1 : 1;
        m_last = b;
        m_have_last = 1'b1;
        if (m_run == RL) begin
            m_fault = 1'b1;
            m_wq.delete();
        end else if (m_disc > 0) begin
            m_disc--;
        end else begin
            m_wq.push_back(b);
            if (m_wq.size() == WB) begin
                w = '0;
                foreach (m_wq[i]) w = (w << 8) | 64'(m_wq[i]);
                m_word = w;
                m_ready = 1'b1;
                m_wq.delete();
            end
        end
    endfunction

    function automatic void model_step(input logic exp_rd);
        int win;
        if (m_grant) begin
            m_grant = 1'b0;
        end else if (m_ready && req != 2'b00) begin
            if (m_rr) win = req[1] ? 1 : 0;
            else      win = req[0] ? 0 : 1;
            m_gvec = (win == 1) ? 2'b10 : 2'b01;
            m_rr = ~m_rr;
            m_seed = m_word;
            m_ready = 1'b0;
            m_grant = 1'b1;
            mseed.push_back(m_seed);
            mgnt.push_back(m_gvec);
        end
        if (m_fault && clear_fault) begin
            m_fault = 1'b0;
            m_disc = WU;
            m_wq.delete();
            m_run = 0;
            m_have_last = 1'b0;
        end
        if (m_pend) model_capture(fifo_dout);
        m_pend = exp_rd;
    endfunction

    task automatic cycle(input logic rst_v);
        logic exp_rd;
        @(negedge clk);
        if (!reset_n) model_reset();
        exp_rd = reset_n && !m_fault && !m_ready && !m_grant && !fifo_empty && !m_pend;
        chk("rd_en", 64'(fifo_rd_en), 64'(exp_rd));
        chk("gnt", 64'(gnt), m_grant ? 64'(m_gvec) : 64'd0);
        chk("seed_valid", 64'(seed_valid), 64'(m_grant));
        chk("seed_data", 64'(seed_data), m_seed);
        chk("health_fault", 64'(health_fault), 64'(m_fault));
        rd_seen = fifo_rd_en;
        if (fifo_rd_en) n_reads++;
        g_seen = gnt;
        if (seed_valid) begin
            dseed.push_back(64'(seed_data));
            dgnt.push_back(gnt);
        end
        if (reset_n) model_step(exp_rd);
        @(posedge clk);
        #1;
        reset_n = rst_v;
        if (rd_seen && fq.size() > 0) fifo_dout = fq.pop_front();
        else fifo_dout = 8'($urandom);
        req_want = req_want & ~g_seen;
        if (rand_mode) begin
            for (int i = 0; i < 2; i++)
                if (!req_want[i] && $urandom_range(0, 3) == 0) req_want[i] = 1'b1;
        end
        req = req_want;
        clear_fault = clr_next;
        clr_next = 1'b0;
        fifo_empty = stall || (fq.size() == 0);
    endtask

    task automatic start();
        fq.delete();
        dseed.delete(); dgnt.delete(); mseed.delete(); mgnt.delete();
        req_want = '0;
        stall = 1'b0;
        rand_mode = 1'b0;
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b1);
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) fq.push_back(8'(v));
    endtask

    task automatic run_until(input int nseeds, input int maxc);
        int c = 0;
        while (dseed.size() < nseeds && c < maxc) begin
            cycle(1'b1);
            c++;
        end
        chk("seed_timeout", 64'(dseed.size()), 64'(nseeds));
    endtask

    initial begin
        int c;
        int qs;
        logic [7:0] lastb;
        reset_n = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout = '0;
        req = '0;
        clear_fault = 1'b0;
        model_reset();

        // warm-up discard then one word to req[0]
        start();
        push_range(8'h00, 8'h13);
        req_want = 2'b01;
        run_until(1, 200);
        repeat (6) cycle(1'b1);
        chk("warm_count", 64'(dseed.size()), 64'd1);
        chk("warm_seed", dseed[0], 64'h10111213);
        chk("warm_gnt", 64'(dgnt[0]), 64'd1);
        chk("warm_model", mseed[0], 64'h10111213);

        // round-robin with both requests held
        start();
        push_range(8'h00, 8'h0f);
        push_range(8'h20, 8'h27);
        req_want = 2'b11;
        run_until(2, 300);
        chk("rr_gnt0", 64'(dgnt[0]), 64'd1);
        chk("rr_seed0", dseed[0], 64'h20212223);
        chk("rr_gnt1", 64'(dgnt[1]), 64'd2);
        chk("rr_seed1", dseed[1], 64'h24252627);
        chk("rr_model1", mseed[1], 64'h24252627);

        // health fault, hold, clear, fresh warm-up
        start();
        push_range(8'h00, 8'h0f);
        repeat (4) fq.push_back(8'h55);
        push_range(8'h60, 8'h6f);
        push_range(8'h30, 8'h33);
        req_want = 2'b01;
        c = 0;
        while (!health_fault && c < 200) begin cycle(1'b1); c++; end
        chk("fault_seen", 64'(health_fault), 64'd1);
        repeat (10) cycle(1'b1);
        chk("fault_fifo_untouched", 64'(fq.size()), 64'd20);
        chk("fault_no_grant", 64'(dseed.size()), 64'd0);
        chk("fault_rd_en", 64'(fifo_rd_en), 64'd0);
        clr_next = 1'b1;
        cycle(1'b1);
        run_until(1, 300);
        chk("fault_cleared", 64'(health_fault), 64'd0);
        chk("fault_seed", dseed[0], 64'h30313233);

        // three repeats do not trip the test
        start();
        push_range(8'h00, 8'h0f);
        repeat (3) fq.push_back(8'h55);
        fq.push_back(8'h56);
        req_want = 2'b01;
        run_until(1, 200);
        chk("nofault_seed", dseed[0], 64'h55555556);
        chk("nofault_flag", 64'(health_fault), 64'd0);

        // FIFO runs dry mid-word
        start();
        push_range(8'h00, 8'h0f);
        fq.push_back(8'hA1);
        fq.push_back(8'hA2);
        req_want = 2'b01;
        c = 0;
        while (fq.size() > 0 && c < 200) begin cycle(1'b1); c++; end
        repeat (10) cycle(1'b1);
        chk("stall_no_grant", 64'(dseed.size()), 64'd0);
        fq.push_back(8'hA3);
        fq.push_back(8'hA4);
        run_until(1, 100);
        chk("stall_seed", dseed[0], 64'hA1A2A3A4);

        // reset while a read is outstanding
        start();
        push_range(8'h00, 8'h07);
        n_reads = 0;
        c = 0;
        while (n_reads < 3 && c < 100) begin cycle(1'b1); c++; end
        reset_n = 1'b0;
        cycle(1'b0);
        #1;
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_valid", 64'(seed_valid), 64'd0);
        chk("rst_data", 64'(seed_data), 64'd0);
        chk("rst_fault", 64'(health_fault), 64'd0);
        fq.delete();
        push_range(8'h40, 8'h4f);
        push_range(8'h50, 8'h53);
        req_want = 2'b01;
        run_until(1, 200);
        chk("rst_seed", dseed[0], 64'h50515253);

        // randomized traffic
        start();
        rand_mode = 1'b1;
        lastb = 8'h00;
        for (int i = 0; i < 4000; i++) begin
            if (fq.size() < 8) begin
                if ($urandom_range(0, 3) != 0) lastb = 8'($urandom);
                fq.push_back(lastb);
            end
            if ($urandom_range(0, 9) == 0) stall = ~stall;
            if ($urandom_range(0, 19) == 0) clr_next = 1'b1;
            cycle(1'b1);
        end
        qs = dseed.size();
        chk("rand_grant_count", 64'(qs), 64'(mseed.size()));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
